// File: rtl/counter_seq_ctrl_pkg.sv
// Shared state codes and sequencing constants for the counter sequencer.
// Imported by the RTL and the bench so both agree on encodings.
// No logic here.
package counter_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int CLEAR_PHASES  = 4;
    localparam int SETTLE_CYCLES = 2;

endpackage

// File: rtl/counter_seq_ctrl_debounce.sv
// Button debouncer: 2-FF synchroniser, stable-level counter, one-cycle press pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles + 1 registered pulse cycle.
// No backpressure: one press pulse per accepted high-to-low level change.
module counter_seq_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic clr_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // Released (high) is the idle level, so reset never fabricates a press.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Start/pause/step/clear sequencer driving an external 4-bit counter's clk and clr.
// Latency: outputs are registered, one cycle after the FSM decision; step-to-compare 3 cycles.
// No backpressure: requests arriving during a pulse or settle window are dropped.
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_DIV        = 50000000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       btn_start_n,
    input  logic       btn_step_n,
    input  logic       sw_auto,
    input  logic [3:0] target,
    input  logic [3:0] cnt_q,
    output logic       cnt_step,
    output logic       cnt_clr,
    output logic [2:0] state,
    output logic       busy,
    output logic       done
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    state_t        st_q, st_d;
    logic [1:0]    phase_q, phase_d;
    logic          act_q, act_d;
    logic          pend_q, pend_d;
    logic [3:0]    tgt_q;
    logic [DW-1:0] div_q;
    logic          start_ev, step_ev, tick, req;
    logic          step_d, clr_d;

    counter_seq_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk   (clk),
        .clr_n (clr_n),
        .btn_n (btn_start_n),
        .press (start_ev)
    );

    counter_seq_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk   (clk),
        .clr_n (clr_n),
        .btn_n (btn_step_n),
        .press (step_ev)
    );

    assign tick = sw_auto && (div_q == DIV_LAST);
    assign req  = sw_auto ? tick : step_ev;

    // act_q marks a pulse/settle window in RUN; phase 0 is the pulse, 1..2 settle.
    always_comb begin
        st_d    = st_q;
        phase_d = phase_q;
        act_d   = act_q;
        pend_d  = pend_q;
        case (st_q)
            ST_IDLE, ST_DONE: begin
                if (start_ev) begin
                    st_d    = ST_CLEAR;
                    phase_d = 2'd0;
                end
            end
            ST_CLEAR: begin
                if (phase_q == 2'(CLEAR_PHASES - 1)) begin
                    st_d    = ST_RUN;
                    phase_d = 2'd0;
                    act_d   = 1'b0;
                    pend_d  = 1'b0;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            ST_RUN: begin
                if (act_q) begin
                    if (phase_q == 2'(SETTLE_CYCLES)) begin
                        act_d   = 1'b0;
                        phase_d = 2'd0;
                        pend_d  = 1'b0;
                        if (cnt_q == tgt_q)
                            st_d = ST_DONE;
                        else if (pend_q || start_ev)
                            st_d = ST_PAUSE;
                    end else begin
                        phase_d = phase_q + 2'd1;
                        if (start_ev)
                            pend_d = 1'b1;
                    end
                end else if (start_ev) begin
                    st_d = ST_PAUSE;
                end else if (req) begin
                    act_d   = 1'b1;
                    phase_d = 2'd0;
                end
            end
            ST_PAUSE: begin
                if (start_ev)
                    st_d = ST_RUN;
            end
            default: begin
                st_d    = ST_IDLE;
                phase_d = 2'd0;
                act_d   = 1'b0;
                pend_d  = 1'b0;
            end
        endcase
        clr_d  = (st_d == ST_CLEAR) && (phase_d != 2'(CLEAR_PHASES - 1));
        step_d = ((st_d == ST_CLEAR) && (phase_d == 2'd1)) ||
                 ((st_d == ST_RUN) && act_d && (phase_d == 2'd0));
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            st_q     <= ST_IDLE;
            phase_q  <= 2'd0;
            act_q    <= 1'b0;
            pend_q   <= 1'b0;
            tgt_q    <= 4'd0;
            div_q    <= '0;
            cnt_step <= 1'b0;
            cnt_clr  <= 1'b0;
        end else begin
            st_q     <= st_d;
            phase_q  <= phase_d;
            act_q    <= act_d;
            pend_q   <= pend_d;
            cnt_step <= step_d;
            cnt_clr  <= clr_d;
            if (st_q == ST_CLEAR && phase_q == 2'd0)
                tgt_q <= target;
            // Cleared outside RUN so every RUN entry restarts a full tick period.
            if (st_q == ST_RUN && sw_auto)
                div_q <= tick ? '0 : div_q + DW'(1);
            else
                div_q <= '0;
        end
    end

    assign state = st_q;
    assign busy  = (st_q == ST_CLEAR) || (st_q == ST_RUN) || (st_q == ST_PAUSE);
    assign done  = (st_q == ST_DONE);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl with a behavioural 4-bit counter on cnt_step/cnt_clr.
module tb_counter_seq_ctrl;
    import counter_seq_ctrl_pkg::*;

    localparam int OP_START = 0;
    localparam int OP_STEP  = 1;
    localparam int OP_BOTH  = 2;
    localparam int OP_WAIT  = 3;

    typedef struct {
        int         op;
        int         hold;
        logic [3:0] tgt;
        logic [2:0] exp_state;
        logic [3:0] exp_q;
        logic       exp_done;
        int         exp_dp;
    } vec_t;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       btn_start_n = 1'b1;
    logic       btn_step_n = 1'b1;
    logic       sw_auto = 1'b0;
    logic [3:0] target = 4'd0;
    logic [3:0] cnt_q = 4'd9;
    logic       cnt_step, cnt_clr, busy, done;
    logic [2:0] state;

    int  vec_cnt = 0;
    int  err_cnt = 0;
    int  pulse_cnt = 0;
    int  clr_cyc = 0;
    int  long_pulse = 0;
    logic prev_step = 1'b0;
    time pulse_t[$];
    vec_t vecs[11];

    always #5 clk = ~clk;

    counter_seq_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_DIV(8)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .btn_start_n (btn_start_n),
        .btn_step_n  (btn_step_n),
        .sw_auto     (sw_auto),
        .target      (target),
        .cnt_q       (cnt_q),
        .cnt_step    (cnt_step),
        .cnt_clr     (cnt_clr),
        .state       (state),
        .busy        (busy),
        .done        (done)
    );

    // Behavioural counter_4bit_sync: synchronous clear on its own clock.
    always @(posedge cnt_step) begin
        cnt_q <= cnt_clr ? 4'd0 : cnt_q + 4'd1;
        pulse_cnt++;
        pulse_t.push_back($time);
    end

    always @(negedge clk) begin
        if (cnt_clr) clr_cyc++;
        if (cnt_step && prev_step) long_pulse++;
        prev_step = cnt_step;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input bit do_start, input bit do_step, input int hold);
        if (do_start) btn_start_n = 1'b0;
        if (do_step)  btn_step_n = 1'b0;
        tick(hold);
        btn_start_n = 1'b1;
        btn_step_n  = 1'b1;
        tick(12);
    endtask

    task automatic drive_btn(input bit on_start, input logic v);
        if (on_start) btn_start_n = v;
        else          btn_step_n = v;
    endtask

    task automatic bounce_press(input bit on_start);
        logic v;
        v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            v = ~v;
            drive_btn(on_start, v);
            tick(2);
        end
        tick(20);
        for (int i = 0; i < 5; i++) begin
            v = ~v;
            drive_btn(on_start, v);
            tick(2);
        end
        tick(20);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, state, ST_IDLE);
        check({tag, "_step"}, cnt_step, 0);
        check({tag, "_clr"}, cnt_clr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        int  p0, c0, n, bad;
        bit  found;
        time seen_t;
        logic exp_busy;

        vecs[0]  = '{OP_STEP,  20, 4'd3, ST_RUN,   4'd1, 1'b0, 1};
        vecs[1]  = '{OP_BOTH,  20, 4'd3, ST_PAUSE, 4'd1, 1'b0, 0};
        vecs[2]  = '{OP_STEP,  20, 4'd3, ST_PAUSE, 4'd1, 1'b0, 0};
        vecs[3]  = '{OP_BOTH,  20, 4'd3, ST_RUN,   4'd1, 1'b0, 0};
        vecs[4]  = '{OP_STEP,  60, 4'd5, ST_RUN,   4'd2, 1'b0, 1};
        vecs[5]  = '{OP_STEP,  20, 4'd5, ST_DONE,  4'd3, 1'b1, 1};
        vecs[6]  = '{OP_STEP,  20, 4'd5, ST_DONE,  4'd3, 1'b1, 0};
        vecs[7]  = '{OP_WAIT,  30, 4'd5, ST_DONE,  4'd3, 1'b1, 0};
        vecs[8]  = '{OP_START, 20, 4'd2, ST_RUN,   4'd0, 1'b0, 1};
        vecs[9]  = '{OP_STEP,  20, 4'd2, ST_RUN,   4'd1, 1'b0, 1};
        vecs[10] = '{OP_STEP,  20, 4'd2, ST_DONE,  4'd2, 1'b1, 1};

        // Reset state
        tick(3);
        check_reset_outputs("reset");
        clr_n = 1'b1;
        tick(2);

        // First start: CLEAR sequence, counter forced to 0, lands in RUN
        target = 4'd3;
        sw_auto = 1'b0;
        c0 = clr_cyc;
        p0 = pulse_cnt;
        press(1, 0, 20);
        check("clear_clr_cycles", clr_cyc - c0, 3);
        check("clear_pulses", pulse_cnt - p0, 1);
        check("clear_cnt_q", cnt_q, 0);
        check("clear_state", state, ST_RUN);
        check("clear_busy", busy, 1);
        check("clear_done", done, 0);

        // Manual-mode table
        for (int i = 0; i < 11; i++) begin
            target = vecs[i].tgt;
            p0 = pulse_cnt;
            case (vecs[i].op)
                OP_START: press(1, 0, vecs[i].hold);
                OP_STEP:  press(0, 1, vecs[i].hold);
                OP_BOTH:  press(1, 1, vecs[i].hold);
                default:  tick(vecs[i].hold);
            endcase
            exp_busy = (vecs[i].exp_state == ST_CLEAR) || (vecs[i].exp_state == ST_RUN) ||
                       (vecs[i].exp_state == ST_PAUSE);
            check($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
            check($sformatf("vec%0d_cnt_q", i), cnt_q, vecs[i].exp_q);
            check($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
            check($sformatf("vec%0d_busy", i), busy, exp_busy);
            check($sformatf("vec%0d_pulses", i), pulse_cnt - p0, vecs[i].exp_dp);
        end

        // Auto mode, target 0: 16 evenly spaced steps with a 15->0 wrap
        sw_auto = 1'b1;
        target = 4'd0;
        p0 = pulse_cnt;
        press(1, 0, 20);
        n = 0;
        while (!done && n < 400) begin
            tick(1);
            n++;
        end
        check("auto_done", done, 1);
        check("auto_pulses", pulse_cnt - p0, 17);
        check("auto_cnt_q", cnt_q, 0);
        check("auto_state", state, ST_DONE);
        if (pulse_t.size() >= p0 + 17) begin
            bad = 0;
            for (int i = p0 + 2; i <= p0 + 16; i++)
                if (pulse_t[i] - pulse_t[i-1] != 80) bad++;
            check("auto_spacing_bad", bad, 0);
            check("auto_first_gap", int'(pulse_t[p0+1] - pulse_t[p0]), 110);
        end else begin
            check("auto_pulse_log", pulse_t.size(), p0 + 17);
        end

        // Auto pause and resume
        target = 4'd15;
        press(1, 0, 20);
        check("pause_pre_state", state, ST_RUN);
        press(1, 0, 20);
        check("pause_state", state, ST_PAUSE);
        p0 = pulse_cnt;
        tick(100);
        check("pause_no_pulses", pulse_cnt - p0, 0);
        check("pause_hold_state", state, ST_PAUSE);
        btn_start_n = 1'b0;
        found = 1'b0;
        seen_t = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (i == 20) btn_start_n = 1'b1;
            if (!found && state == ST_RUN) begin
                found = 1'b1;
                seen_t = $time;
            end
        end
        check("resume_seen_run", found, 1);
        if (pulse_cnt > p0)
            check("resume_first_gap", int'(pulse_t[p0] - (seen_t - 1)), 80);
        else
            check("resume_pulse_seen", pulse_cnt - p0, 1);

        // Bouncy presses give exactly one event each
        sw_auto = 1'b0;
        tick(12);
        press(1, 0, 20);
        check("bounce_pre_state", state, ST_PAUSE);
        bounce_press(1);
        check("bounce_start_state", state, ST_RUN);
        p0 = pulse_cnt;
        bounce_press(0);
        check("bounce_step_pulses", pulse_cnt - p0, 1);
        check("bounce_step_state", state, ST_RUN);

        // Reset during a RUN pulse
        btn_step_n = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick(1);
            if (cnt_step) found = 1'b1;
        end
        check("rst_run_pulse_seen", found, 1);
        clr_n = 1'b0;
        btn_step_n = 1'b1;
        tick(1);
        check_reset_outputs("rst_run");
        clr_n = 1'b1;
        tick(10);
        check("rst_run_idle_hold", state, ST_IDLE);

        // Reset during CLEAR p1, then a full CLEAR again
        btn_start_n = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick(1);
            if (cnt_step && state == ST_CLEAR) found = 1'b1;
        end
        check("rst_clr_p1_seen", found, 1);
        clr_n = 1'b0;
        btn_start_n = 1'b1;
        tick(1);
        check_reset_outputs("rst_clr");
        clr_n = 1'b1;
        tick(10);
        check("rst_clr_idle_hold", state, ST_IDLE);
        target = 4'd7;
        c0 = clr_cyc;
        p0 = pulse_cnt;
        press(1, 0, 20);
        check("reclear_clr_cycles", clr_cyc - c0, 3);
        check("reclear_pulses", pulse_cnt - p0, 1);
        check("reclear_cnt_q", cnt_q, 0);
        check("reclear_state", state, ST_RUN);

        check("single_cycle_pulses", long_pulse, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
